// File: rtl/edge_count_pkg.sv
// Shared types and constants for the edge-count controller and its bench.
// The optional EDGE_COUNT_BOTH_EDGES_EN build only changes edge_qual.
package edge_count_pkg;

  localparam int CNT_W_DEF = 4;
  localparam int TMO_W_DEF = 8;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ARM    = 2'b01;
  localparam logic [1:0] ST_COUNT  = 2'b10;
  localparam logic [1:0] ST_FINISH = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ARM    = ST_ARM,
    COUNT  = ST_COUNT,
    FINISH = ST_FINISH
  } state_t;

  // Why a run ended, as seen on the done/tmo pulse pair.
  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_DONE = 2'b01,
    CAUSE_TMO  = 2'b10
  } cause_t;

  function automatic cause_t finish_cause(input logic done, input logic tmo);
    if (done && !tmo)      return CAUSE_DONE;
    else if (tmo && !done) return CAUSE_TMO;
    else                   return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/edge_count_ctrl_qual.sv
// Edge qualifier: history register plus rise (or, with EDGE_COUNT_BOTH_EDGES_EN,
// rise-or-fall) detect; load primes the history so a pre-existing level is not an edge.
module edge_qual
  import edge_count_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic sig,
  output logic edge_pulse
);

`ifdef EDGE_COUNT_BOTH_EDGES_EN
  localparam logic BOTH_EDGES = 1'b1;
`else
  localparam logic BOTH_EDGES = 1'b0;
`endif

  logic hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      hist <= 1'b0;
    else if (load || en)
      hist <= sig;
  end

  assign edge_pulse = en & (BOTH_EDGES ? (sig ^ hist) : (sig & ~hist));

endmodule

// File: rtl/edge_count_ctrl.sv
// Run controller: arms edge_qual, counts edges to a latched target, aborts on timeout.
// Build option EDGE_COUNT_BOTH_EDGES_EN (in edge_qual) counts falling edges too.
module edge_count_ctrl
  import edge_count_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] target,
  input  logic [TMO_W-1:0] timeout,
  input  logic             sig,
  output logic             det_en,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tmo
);

  state_t           state;
  logic [CNT_W-1:0] tgt_l;
  logic [TMO_W-1:0] tmo_l;
  logic [TMO_W-1:0] timer;
  logic [CNT_W-1:0] count_inc;
  logic             edge_pulse;
  logic             in_count;
  logic             arm_load;
  logic             final_edge;
  logic             expire;

  assign in_count   = (state == COUNT);
  assign arm_load   = (state == ARM);
  assign det_en     = arm_load | in_count;
  assign busy       = (state != IDLE);
  assign count_inc  = count + 1'b1;
  assign final_edge = edge_pulse && (count_inc == tgt_l);
  assign expire     = (tmo_l != '0) && (timer == tmo_l - 1'b1);

  edge_qual u_qual (
    .clk        (clk),
    .rst        (rst),
    .en         (in_count),
    .load       (arm_load),
    .sig        (sig),
    .edge_pulse (edge_pulse)
  );

  // done/tmo are set only on the transition into FINISH, so each lasts one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      tgt_l <= '0;
      tmo_l <= '0;
      timer <= '0;
      done  <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      done <= 1'b0;
      tmo  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tgt_l <= target;
            tmo_l <= timeout;
            count <= '0;
            timer <= '0;
            if (target == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= ARM;
            end
          end
        end
        ARM: state <= COUNT;
        COUNT: begin
          if (edge_pulse)
            count <= count_inc;
          // A terminating edge beats a simultaneous timeout; the timer freezes at expiry.
          if (final_edge) begin
            state <= FINISH;
            done  <= 1'b1;
          end else if (expire) begin
            state <= FINISH;
            tmo   <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_count_ctrl.sv
// Scoreboard bench for edge_count_ctrl; expectations follow the EDGE_COUNT_BOTH_EDGES_EN
// build setting so the same bench covers both builds.
module tb_edge_count_ctrl;
  import edge_count_pkg::*;

  typedef struct packed {
    cause_t     cause;
    logic [3:0] cnt;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] target;
  logic [7:0] timeout;
  logic       sig;
  logic       det_en;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       tmo;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  edge_count_ctrl #(.CNT_W(4), .TMO_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .target  (target),
    .timeout (timeout),
    .sig     (sig),
    .det_en  (det_en),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .tmo     (tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic bitat(input string p, input int i);
    if (i < p.len()) return (p[i] == "1");
    return (p[p.len()-1] == "1");
  endfunction

  // Reference: pattern char 0 is sampled in ARM, char i (i>=1) in COUNT cycle i.
  function automatic exp_t model(input string p, input logic [3:0] tgt, input logic [7:0] to);
    exp_t e;
    logic h, s, ed;
    e.cause = CAUSE_NONE;
    e.cnt   = 4'd0;
    e.cyc   = 0;
    h = bitat(p, 0);
    for (int i = 1; i <= 61; i++) begin
      s = bitat(p, i);
`ifdef EDGE_COUNT_BOTH_EDGES_EN
      ed = (s != h);
`else
      ed = s && !h;
`endif
      if (ed) e.cnt = e.cnt + 4'd1;
      if (ed && e.cnt == tgt) begin
        e.cause = CAUSE_DONE;
        e.cyc   = i + 1;
        return e;
      end else if (to != 8'd0 && (i - 1) == (int'(to) - 1)) begin
        e.cause = CAUSE_TMO;
        e.cyc   = i + 1;
        return e;
      end
      h = s;
    end
    return e;
  endfunction

  task automatic launch(input logic [3:0] tgt, input logic [7:0] to);
    target  = tgt;
    timeout = to;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  // Drives the pattern until a pulse appears or the cycle budget runs out.
  task automatic run(input string p, output exp_t obs);
    obs.cause = CAUSE_NONE;
    obs.cnt   = count;
    obs.cyc   = 0;
    sig = bitat(p, 0);
    for (int i = 1; i <= 62; i++) begin
      @(posedge clk); #1;
      if (done || tmo) begin
        obs.cause = finish_cause(done, tmo);
        obs.cnt   = count;
        obs.cyc   = i;
        return;
      end
      sig = bitat(p, i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sig = 1'b0; target = 4'd0; timeout = 8'd0;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({count, done, tmo, det_en, busy} !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_state got=%h exp=00", {count, done, tmo, det_en, busy});
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_count_rising();
    exp_t obs, e;
    sb.push_back(model("00110011001100", 4'd3, 8'd0));
    launch(4'd3, 8'd0);
    total++;
    if (det_en !== 1'b1) begin
      bad++; $display("[TB] FAIL arm_det_en got=%b exp=1", det_en);
    end
    run("00110011001100", obs);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL rise3 got cause=%0d cnt=%0d cyc=%0d exp cause=%0d cnt=%0d cyc=%0d",
               obs.cause, obs.cnt, obs.cyc, e.cause, e.cnt, e.cyc);
    end
    total++;
    if ({busy, det_en} !== 2'b10) begin
      bad++; $display("[TB] FAIL finish_flags got=%b exp=10", {busy, det_en});
    end
    @(posedge clk); #1;
    total++;
    if ({busy, done, tmo, count} !== {3'b000, 4'd3}) begin
      bad++; $display("[TB] FAIL idle_after_done got=%h exp=%h", {busy, done, tmo, count}, {3'b000, 4'd3});
    end
  endtask

  task automatic test_timeout();
    exp_t obs, e;
    sb.push_back(model("0", 4'd5, 8'd10));
    launch(4'd5, 8'd10);
    run("0", obs);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL timeout10 got cause=%0d cnt=%0d cyc=%0d exp cause=%0d cnt=%0d cyc=%0d",
               obs.cause, obs.cnt, obs.cyc, e.cause, e.cnt, e.cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_armed_high();
    exp_t obs, e;
    sb.push_back(model("111111101", 4'd1, 8'd0));
    launch(4'd1, 8'd0);
    run("111111101", obs);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL armed_high got cause=%0d cnt=%0d cyc=%0d exp cause=%0d cnt=%0d cyc=%0d",
               obs.cause, obs.cnt, obs.cyc, e.cause, e.cnt, e.cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_edge_on_timeout();
    exp_t obs, e;
    sb.push_back(model("010101001", 4'd4, 8'd8));
    launch(4'd4, 8'd8);
    run("010101001", obs);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL edge_vs_timeout got cause=%0d cnt=%0d cyc=%0d exp cause=%0d cnt=%0d cyc=%0d",
               obs.cause, obs.cnt, obs.cyc, e.cause, e.cnt, e.cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    exp_t obs, e;
    logic reached;
    reached = 1'b0;
    launch(4'd5, 8'd0);
    sig = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (count == 4'd2) begin
        reached = 1'b1;
        break;
      end
      sig = ~sig;
    end
    total++;
    if (reached !== 1'b1) begin
      bad++; $display("[TB] FAIL reach_count2 got count=%0d exp=2", count);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({count, done, tmo, det_en, busy} !== 8'h00) begin
      bad++; $display("[TB] FAIL async_clear got=%h exp=00", {count, done, tmo, det_en, busy});
    end
    @(posedge clk); #1;
    total++;
    if ({done, tmo} !== 2'b00) begin
      bad++; $display("[TB] FAIL no_pulse_in_reset got=%b exp=00", {done, tmo});
    end
    rst = 1'b1;
    sb.push_back(model("0101", 4'd2, 8'd0));
    launch(4'd2, 8'd0);
    run("0101", obs);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL fresh_run got cause=%0d cnt=%0d cyc=%0d exp cause=%0d cnt=%0d cyc=%0d",
               obs.cause, obs.cnt, obs.cyc, e.cause, e.cnt, e.cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_target_zero();
    exp_t obs, e;
    sb.push_back('{cause: CAUSE_DONE, cnt: 4'd0, cyc: 1});
    launch(4'd0, 8'd0);
    obs.cause = finish_cause(done, tmo);
    obs.cnt   = count;
    obs.cyc   = 1;
    e = sb.pop_front();
    total++;
    if (obs !== e || {busy, det_en} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL target0 got cause=%0d cnt=%0d busy=%b det_en=%b exp cause=%0d cnt=%0d busy=1 det_en=0",
               obs.cause, obs.cnt, busy, det_en, e.cause, e.cnt);
    end
    @(posedge clk); #1;
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++; $display("[TB] FAIL target0_idle got=%b exp=00", {busy, done});
    end
  endtask

  task automatic test_both_edges();
    exp_t obs, e;
    sb.push_back(model("0110011000", 4'd4, 8'd12));
    launch(4'd4, 8'd12);
    run("0110011000", obs);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL two_pulses got cause=%0d cnt=%0d cyc=%0d exp cause=%0d cnt=%0d cyc=%0d",
               obs.cause, obs.cnt, obs.cyc, e.cause, e.cnt, e.cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t obs, e;
    logic [3:0] seen;
    target = 4'd0;
    start  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen[i] = done;
    end
    start = 1'b0;
    total++;
    if (seen !== 4'b0101) begin
      bad++; $display("[TB] FAIL held_start got=%b exp=0101", seen);
    end
    @(posedge clk); #1;
    sb.push_back(model("0101", 4'd2, 8'd0));
    launch(4'd2, 8'd0);
    target = 4'd0;
    start  = 1'b1;
    run("0101", obs);
    start  = 1'b0;
    e = sb.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL start_ignored got cause=%0d cnt=%0d cyc=%0d exp cause=%0d cnt=%0d cyc=%0d",
               obs.cause, obs.cnt, obs.cyc, e.cause, e.cnt, e.cyc);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_count_rising();
    test_timeout();
    test_armed_high();
    test_edge_on_timeout();
    test_reset_mid_run();
    test_target_zero();
    test_both_edges();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_count_ctrl.md
Name: edge_count_ctrl

Overview:
- Sequences a single edge detector on one input line.
- Arms the detector, counts qualified edges up to a programmed target, and aborts on a cycle timeout.
- Reports completion with one-cycle pulses.
- Sits between a host/control FSM and the raw detector datapath, and owns the detector's enable.

Parameters:
CNT_W, 4, width of target and edge count
TMO_W, 8, width of timeout cycle counter

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request to begin a count run; sampled only in IDLE
target  input  CNT_W  number of edges to count; latched on accepted start
timeout  input  TMO_W  max cycles in COUNT; 0 = no timeout; latched on accepted start
sig  input  1  monitored line, already synchronous to clk
det_en  output  1  detector enable, high in ARM and COUNT
count  output  CNT_W  edges counted in current/last run
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse: target reached
tmo  output  1  one-cycle pulse: timeout expired before target

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; count=0; done=0; tmo=0; det_en=0; busy=0.
  - Latched target/timeout, timer and detector history register all cleared.
  - Reset mid-run aborts with no done/tmo pulse.
- State IDLE:
  - On start=1: latch target and timeout, clear count and timer.
  - If target==0: go to FINISH with done set. Otherwise go to ARM.
- State ARM (exactly 1 cycle):
  - det_en=1.
  - Detector history loaded with current sig, so a line already high at arm is not counted.
  - Next state: COUNT.
- State COUNT:
  - Rising edge = sig sampled 1 while history=0. History updates every cycle.
  - Each edge increments count at that same clock edge.
  - If the increment makes count==target_latched: go to FINISH, done set.
  - Timer increments every COUNT cycle. If timeout_latched!=0 and timer==timeout_latched-1 with no terminating edge that cycle: go to FINISH, tmo set.
  - Simultaneous final edge and timeout expiry: done wins, tmo stays 0.
- State FINISH (exactly 1 cycle):
  - det_en=0; busy=1.
  - Exactly one of done/tmo is high (registered, glitch-free).
  - Next state: IDLE.
- start outside IDLE is ignored (no queuing). start held high re-triggers a new run from the first IDLE cycle after FINISH.
- count holds its final value until the next accepted start.
- Latency:
  - start accepted → det_en high on next cycle.
  - Final edge sampled → done high during the following cycle.
- Arithmetic:
  - count is unsigned CNT_W and cannot wrap, because the run terminates at target ≤ 2^CNT_W-1.
  - Timer is unsigned TMO_W and saturates at the terminating compare.

Optional Feature:
- Macro EDGE_COUNT_BOTH_EDGES_EN.
- Defined: falling edges (sig=0, history=1) also count, so each full pulse adds 2. The ARM history-load rule still applies.
- Undefined: rising edges only.
- Port list identical in both builds.

Decomposition:
- Package edge_count_pkg holds:
  - state enum typedef (IDLE, ARM, COUNT, FINISH) with fixed 2-bit encoding 00/01/10/11;
  - default width constants;
  - a FINISH-cause encoding used by the bench.
- One sub-module, edge_qual, contains:
  - the history register;
  - an enable input;
  - a load input (ARM history load);
  - the rise/fall detect logic, with both-edge select tied to the macro;
  - one output: edge pulse (combinational from the registered history).
- The controller instantiates edge_qual once.

Test Plan:
- target=3, timeout=0, sig pulses high 2 cycles/low 2 cycles → count 1,2,3; done pulse 1 cycle after 3rd rising edge; tmo=0; busy falls next cycle.
- target=5, timeout=10, sig stuck 0 → tmo pulse after 10 COUNT cycles; done=0; count=0.
- sig already 1 at start, target=1, sig stays 1 for 6 cycles then toggles 0→1 → no count until the 0→1 transition; then done.
- Final (4th) edge lands on the timeout cycle, target=4, timeout=8 → done=1, tmo=0.
- rst driven low mid-COUNT with count=2 → outputs clear immediately (async); no pulse; start after release begins a fresh run.
- target=0 with start → busy for 1 cycle, done pulse, count=0; plus with EDGE_COUNT_BOTH_EDGES_EN and target=4, two full pulses → done.
